// File: rtl/rtc_alarm_pkg.sv
// Purpose: shared constants, alarm mode type and status-width helper for the RTC timebase core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rtc_alarm_pkg;

    // Bit map of the interrupt status / enable vectors.
    localparam int ISTA_TICK      = 0;
    localparam int ISTA_OV        = 1;
    localparam int ISTA_ALRM_BASE = 2;

    typedef enum logic {
        ALRM_ONESHOT  = 1'b0,
        ALRM_PERIODIC = 1'b1
    } alrm_mode_e;

    // Two fixed status bits (tick, overflow) followed by one bit per alarm channel.
    function automatic int ista_width(input int num_alrm);
        return num_alrm + ISTA_ALRM_BASE;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Purpose: free-running prescaler; emits tick_int once every pscr_i+1 enabled cycles.
// Latency: tick_int is combinational from the pcnt flop; clear takes effect next edge.
// Backpressure: none; en_i gates counting, clr_i restarts the period.
//
// Ports: clk_i/rst_n_i clock and async active-low reset; en_i enable level;
//        clr_i restart strobe (counter load); pscr_i divide value; tick_int event out.
module rtc_prescaler #(
    parameter int PSCR_WIDTH = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [PSCR_WIDTH-1:0] pscr_i,
    output logic                  tick_int
);

    logic [PSCR_WIDTH-1:0] pcnt_q;

    // >= rather than == so that lowering pscr_i below the running count
    // ends the current period immediately instead of waiting for a wrap.
    assign tick_int = en_i && (pcnt_q >= pscr_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pcnt_q <= '0;
        end else if (clr_i) begin
            pcnt_q <= '0;
        end else if (en_i) begin
            if (pcnt_q >= pscr_i) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + PSCR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_alarm_core.sv
// Purpose: RTC timebase: prescaler, wrapping counter, NUM_ALRM one-shot/periodic alarms, W1C status.
// Latency: tick period pscr_i+1 cycles; event to ista_o/tick_o/irq_o is one cycle.
// Backpressure: none; every strobe is accepted in the cycle it is presented.
//
// Ports: en_i/pscr_i timebase control; cnt_wr_i/cnt_wdata_i counter load;
//        alrm_wr_i/alrm_wdata_i/alrm_mode_i per-channel alarm load; ie_i enables;
//        ista_clr_i W1C clears; cnt_o count; ista_o status; tick_o tick pulse; irq_o interrupt.
module rtc_alarm_core
    import rtc_alarm_pkg::*;
#(
    parameter int CNT_WIDTH  = 32,
    parameter int PSCR_WIDTH = 20,
    parameter int NUM_ALRM   = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            en_i,
    input  logic [PSCR_WIDTH-1:0]           pscr_i,
    input  logic                            cnt_wr_i,
    input  logic [CNT_WIDTH-1:0]            cnt_wdata_i,
    input  logic [NUM_ALRM-1:0]             alrm_wr_i,
    input  logic [CNT_WIDTH-1:0]            alrm_wdata_i,
    input  logic [NUM_ALRM-1:0]             alrm_mode_i,
    input  logic [ista_width(NUM_ALRM)-1:0] ie_i,
    input  logic [ista_width(NUM_ALRM)-1:0] ista_clr_i,
    output logic [CNT_WIDTH-1:0]            cnt_o,
    output logic [ista_width(NUM_ALRM)-1:0] ista_o,
    output logic                            tick_o,
    output logic                            irq_o
);

    localparam int IW = ista_width(NUM_ALRM);

    logic                 tick_int;
    logic                 tick_acc;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic [IW-1:0]        ista_q;
    logic [IW-1:0]        ista_set;
    logic                 tick_q;
    logic [NUM_ALRM-1:0]  alrm_hit;

    rtc_prescaler #(
        .PSCR_WIDTH (PSCR_WIDTH)
    ) u_prescaler (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (en_i),
        .clr_i    (cnt_wr_i),
        .pscr_i   (pscr_i),
        .tick_int (tick_int)
    );

    // A counter load swallows a coincident tick along with its overflow/alarm side effects.
    assign tick_acc = tick_int & ~cnt_wr_i;
    assign cnt_nxt  = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_acc;
            if (cnt_wr_i) begin
                cnt_q <= cnt_wdata_i;
            end else if (tick_acc) begin
                cnt_q <= cnt_nxt;
            end
        end
    end

    always_comb begin
        ista_set                              = '0;
        ista_set[ISTA_TICK]                   = tick_acc;
        ista_set[ISTA_OV]                     = tick_acc & (&cnt_q);
        ista_set[IW-1:ISTA_ALRM_BASE]         = alrm_hit;
    end

    // Set wins over a same-cycle clear so no event is ever lost.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ista_q <= '0;
        end else begin
            ista_q <= (ista_q & ~ista_clr_i) | ista_set;
        end
    end

    for (genvar k = 0; k < NUM_ALRM; k++) begin : g_alrm
        logic [CNT_WIDTH-1:0] cmp_q;
        logic [CNT_WIDTH-1:0] period_q;
        logic                 armed_q;
        alrm_mode_e           mode_q;
        alrm_mode_e           mode_in;

        assign mode_in = alrm_mode_e'(alrm_mode_i[k]);

        // Compare against the post-increment count so the status bit lands
        // on the same edge that cnt_o shows the matching value. A load on
        // this channel in the same cycle discards the match.
        assign alrm_hit[k] = tick_acc & armed_q & (cnt_nxt == cmp_q) & ~alrm_wr_i[k];

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                cmp_q    <= '0;
                period_q <= '0;
                armed_q  <= 1'b0;
                mode_q   <= ALRM_ONESHOT;
            end else if (alrm_wr_i[k]) begin
                period_q <= alrm_wdata_i;
                mode_q   <= mode_in;
                if (mode_in == ALRM_PERIODIC) begin
                    // Periodic alarms are relative to the count at load time;
                    // a zero period would never advance, so it stays disarmed.
                    cmp_q   <= cnt_q + alrm_wdata_i;
                    armed_q <= |alrm_wdata_i;
                end else begin
                    cmp_q   <= alrm_wdata_i;
                    armed_q <= 1'b1;
                end
            end else if (alrm_hit[k]) begin
                if (mode_q == ALRM_ONESHOT) begin
                    armed_q <= 1'b0;
                end else begin
                    cmp_q <= cmp_q + period_q;
                end
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign ista_o = ista_q;
    assign tick_o = tick_q;
    assign irq_o  = |(ista_q & ie_i);

endmodule

// File: tb/tb_rtc_alarm_core.sv
// Purpose: self-checking bench for rtc_alarm_core (8-bit counter, 4 alarm channels).
// Latency: expectations are queued with the stimulus and compared one cycle later.
// Backpressure: n/a.
module tb_rtc_alarm_core;

    localparam int CW = 8;
    localparam int PW = 8;
    localparam int NA = 4;
    localparam int IW = NA + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [PW-1:0] pscr;
    logic          cnt_wr;
    logic [CW-1:0] cnt_wdata;
    logic [NA-1:0] alrm_wr;
    logic [CW-1:0] alrm_wdata;
    logic [NA-1:0] alrm_mode;
    logic [IW-1:0] ie;
    logic [IW-1:0] ista_clr;
    logic [CW-1:0] cnt;
    logic [IW-1:0] ista;
    logic          tick;
    logic          irq;

    always #5 clk = ~clk;

    rtc_alarm_core #(
        .CNT_WIDTH  (CW),
        .PSCR_WIDTH (PW),
        .NUM_ALRM   (NA)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .en_i         (en),
        .pscr_i       (pscr),
        .cnt_wr_i     (cnt_wr),
        .cnt_wdata_i  (cnt_wdata),
        .alrm_wr_i    (alrm_wr),
        .alrm_wdata_i (alrm_wdata),
        .alrm_mode_i  (alrm_mode),
        .ie_i         (ie),
        .ista_clr_i   (ista_clr),
        .cnt_o        (cnt),
        .ista_o       (ista),
        .tick_o       (tick),
        .irq_o        (irq)
    );

    typedef enum {S_CNT, S_ISTA, S_TICK, S_IRQ} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input string tag, input sel_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic push_state(input string tag, input int c, input int st, input int tk);
        push(tag, S_CNT,  32'(c));
        push(tag, S_ISTA, 32'(st));
        push(tag, S_TICK, 32'(tk));
    endtask

    task automatic compare_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                S_CNT:   obs = {24'h0, cnt};
                S_ISTA:  obs = {26'h0, ista};
                S_TICK:  obs = {31'h0, tick};
                default: obs = {31'h0, irq};
            endcase
            chk({e.tag, "/", e.sel.name()}, obs, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        pscr       = '0;
        cnt_wr     = 1'b0;
        cnt_wdata  = '0;
        alrm_wr    = '0;
        alrm_wdata = '0;
        alrm_mode  = '0;
        ie         = '0;
        ista_clr   = '0;

        // Reset state
        step(2);
        push_state("reset", 0, 0, 0);
        push("reset", S_IRQ, 0);
        compare_all();

        // 1: pscr=3, tick every 4 cycles, enable freeze
        rst_n = 1'b1;
        en    = 1'b1;
        pscr  = 8'd3;
        for (int i = 1; i <= 3; i++) begin
            step(3);
            push("t1_pre", S_TICK, 0);
            push("t1_pre", S_CNT, 32'(i - 1));
            compare_all();
            step(1);
            push_state("t1_tick", i, 1, 1);
            compare_all();
        end
        en = 1'b0;
        step(10);
        push_state("t1_frozen", 3, 1, 0);
        compare_all();
        en = 1'b1;
        step(3);
        push("t1_resume_pre", S_CNT, 3);
        push("t1_resume_pre", S_TICK, 0);
        compare_all();
        step(1);
        push_state("t1_resume", 4, 1, 1);
        compare_all();

        // 2: wrap sets overflow, irq masking, W1C
        en       = 1'b0;
        ista_clr = '1;
        step(1);
        ista_clr = '0;
        push("t2_clr", S_ISTA, 0);
        compare_all();
        cnt_wr    = 1'b1;
        cnt_wdata = 8'hFE;
        pscr      = 8'd0;
        en        = 1'b1;
        ie        = 6'b000010;
        step(1);
        push_state("t2_load", 8'hFE, 0, 0);
        compare_all();
        cnt_wr = 1'b0;
        step(1);
        push_state("t2_ff", 8'hFF, 1, 1);
        push("t2_ff", S_IRQ, 0);
        compare_all();
        step(1);
        push_state("t2_wrap", 0, 3, 1);
        push("t2_wrap", S_IRQ, 1);
        compare_all();
        en       = 1'b0;
        ista_clr = 6'b000010;
        step(1);
        ista_clr = '0;
        push_state("t2_ovclr", 0, 1, 0);
        push("t2_ovclr", S_IRQ, 0);
        compare_all();

        // 3: one-shot channel 0 at 5, no re-fire after wrap
        cnt_wr     = 1'b1;
        cnt_wdata  = 8'd0;
        alrm_wr    = 4'b0001;
        alrm_wdata = 8'd5;
        alrm_mode  = 4'b0000;
        ista_clr   = '1;
        step(1);
        push_state("t3_load", 0, 0, 0);
        compare_all();
        cnt_wr   = 1'b0;
        alrm_wr  = '0;
        ista_clr = '0;
        en       = 1'b1;
        step(4);
        push_state("t3_pre", 4, 1, 1);
        compare_all();
        step(1);
        push_state("t3_fire", 5, 6'b000101, 1);
        compare_all();
        ista_clr = 6'b000100;
        step(1);
        ista_clr = '0;
        push_state("t3_clr", 6, 1, 1);
        compare_all();
        step(255);
        push_state("t3_nofire", 5, 3, 1);
        push("t3_nofire", S_IRQ, 1);
        compare_all();

        // 4: periodic channel 1, period 3 from cnt 10
        en        = 1'b0;
        cnt_wr    = 1'b1;
        cnt_wdata = 8'd10;
        ista_clr  = '1;
        step(1);
        push_state("t4_cnt", 10, 0, 0);
        compare_all();
        cnt_wr     = 1'b0;
        ista_clr   = '0;
        alrm_wr    = 4'b0010;
        alrm_mode  = 4'b0010;
        alrm_wdata = 8'd3;
        step(1);
        alrm_wr   = '0;
        alrm_mode = '0;
        en        = 1'b1;
        step(3);
        push_state("t4_13", 13, 6'b001001, 1);
        compare_all();
        for (int c = 16; c <= 19; c += 3) begin
            ista_clr = 6'b001000;
            step(1);
            ista_clr = '0;
            push_state("t4_gap", c - 2, 1, 1);
            compare_all();
            step(2);
            push_state("t4_fire", c, 6'b001001, 1);
            compare_all();
        end
        en         = 1'b0;
        alrm_wr    = 4'b0010;
        alrm_mode  = 4'b0010;
        alrm_wdata = 8'd0;
        ista_clr   = '1;
        step(1);
        alrm_wr   = '0;
        alrm_mode = '0;
        ista_clr  = '0;
        en        = 1'b1;
        step(256);
        push_state("t4_zero", 19, 3, 1);
        compare_all();

        // 5: load beats tick, clear on load cycle; set beats clear
        cnt_wr    = 1'b1;
        cnt_wdata = 8'h40;
        ista_clr  = 6'b000001;
        step(1);
        push_state("t5_load", 8'h40, 2, 0);
        compare_all();
        cnt_wr = 1'b0;
        step(1);
        ista_clr = '0;
        push_state("t5_setclr", 8'h41, 3, 1);
        compare_all();

        // 6: async reset mid-count
        en         = 1'b0;
        cnt_wr     = 1'b1;
        cnt_wdata  = 8'd3;
        alrm_wr    = 4'b0001;
        alrm_mode  = 4'b0000;
        alrm_wdata = 8'd9;
        ista_clr   = '1;
        ie         = 6'b000001;
        step(1);
        cnt_wr   = 1'b0;
        alrm_wr  = '0;
        ista_clr = '0;
        pscr     = 8'd2;
        en       = 1'b1;
        step(12);
        push_state("t6_pre", 7, 1, 1);
        push("t6_pre", S_IRQ, 1);
        compare_all();
        step(1);
        rst_n = 1'b0;
        #2;
        push_state("t6_rst", 0, 0, 0);
        push("t6_rst", S_IRQ, 0);
        compare_all();
        step(1);
        rst_n = 1'b1;
        step(2);
        push_state("t6_rel_pre", 0, 0, 0);
        compare_all();
        step(1);
        push_state("t6_first", 1, 1, 1);
        compare_all();
        step(24);
        push_state("t6_unarmed", 9, 1, 1);
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
